// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V fetch stage with in-order variable-latency imem, fetch queue and F->D register.
// Optional FETCH_STATS_EN adds StatBubbles/StatDiscards counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          QUEUE_DEPTH     = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemReady,
   input  logic        ImemRValid,
   input  logic [31:0] ImemRData,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] StatBubbles,
   output logic [31:0] StatDiscards
`endif
);
   localparam int QW = $clog2(QUEUE_DEPTH);
   localparam int CW = $clog2(QUEUE_DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [31:0] QD  = QUEUE_DEPTH;
   localparam logic [31:0] MO  = MAX_OUTSTANDING;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   r_pcf;
   logic [31:0]   r_q_instr [QUEUE_DEPTH];
   logic [31:0]   r_q_pc    [QUEUE_DEPTH];
   logic [QW-1:0] r_q_rd, r_q_wr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_tag [MAX_OUTSTANDING];
   logic [TW-1:0] r_tag_rd, r_tag_wr;
   logic [OW-1:0] r_outst, r_discard;
   logic [31:0]   r_instr_d, r_pc_d, r_pcp4_d;
   logic          r_valid_d;

   logic          w_req, w_acc, w_drop, w_deliv, w_live, w_q_ne;
   logic          w_push, w_pop, w_bypass, w_bubble;
   logic [31:0]   w_tag_pc;

   function automatic logic [TW-1:0] inc_tag(input logic [TW-1:0] p);
      return (32'(p) == MO - 32'd1) ? '0 : p + 1'b1;
   endfunction

   // The count bound reserves a queue slot for every in-flight request.
   assign w_req    = !rst & !StallF & !PCSrcE & (32'(r_outst) < MO)
                   & (32'(r_count) + 32'(r_outst) < QD);
   assign w_acc    = w_req & ImemReady;
   assign w_drop   = ImemRValid & (PCSrcE | (r_discard != '0));
   assign w_deliv  = ImemRValid & !w_drop;
   assign w_live   = !PCSrcE & !StallD & !FlushD;
   assign w_q_ne   = r_count != '0;
   assign w_pop    = w_live & w_q_ne;
   assign w_push   = w_deliv & (StallD | FlushD | w_q_ne);
   assign w_bypass = w_live & !w_q_ne & w_deliv;
   assign w_bubble = w_live & !w_q_ne & !w_deliv;
   assign w_tag_pc = r_tag[r_tag_rd];

   assign ImemReq  = w_req;
   assign ImemAddr = r_pcf;
   assign InstrD   = r_instr_d;
   assign PCD      = r_pc_d;
   assign PCPlus4D = r_pcp4_d;
   assign ValidD   = r_valid_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcf     <= RESET_PC;
         r_q_rd    <= '0;
         r_q_wr    <= '0;
         r_count   <= '0;
         r_tag_rd  <= '0;
         r_tag_wr  <= '0;
         r_outst   <= '0;
         r_discard <= '0;
      end else begin
         r_outst <= r_outst + OW'(w_acc) - OW'(ImemRValid);
         if (PCSrcE) begin
            r_pcf     <= PCTargetE;
            r_q_rd    <= '0;
            r_q_wr    <= '0;
            r_count   <= '0;
            r_tag_rd  <= '0;
            r_tag_wr  <= '0;
            r_discard <= r_outst - OW'(ImemRValid);
         end else begin
            if (w_acc) r_pcf <= r_pcf + 32'd4;
            if (w_acc) r_tag_wr <= inc_tag(r_tag_wr);
            if (w_deliv) r_tag_rd <= inc_tag(r_tag_rd);
            if (ImemRValid && r_discard != '0) r_discard <= r_discard - 1'b1;
            if (w_push) r_q_wr <= r_q_wr + 1'b1;
            if (w_pop) r_q_rd <= r_q_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) r_tag[r_tag_wr] <= r_pcf;
      if (w_push) begin
         r_q_instr[r_q_wr] <= ImemRData;
         r_q_pc[r_q_wr]    <= w_tag_pc;
      end
   end

   // Bubbles keep PCD/PCPlus4D; only the valid bit and instruction change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr_d <= NOP;
         r_pc_d    <= '0;
         r_pcp4_d  <= '0;
         r_valid_d <= 1'b0;
      end else if (PCSrcE || (!StallD && FlushD) || w_bubble) begin
         r_instr_d <= NOP;
         r_valid_d <= 1'b0;
      end else if (w_pop) begin
         r_instr_d <= r_q_instr[r_q_rd];
         r_pc_d    <= r_q_pc[r_q_rd];
         r_pcp4_d  <= r_q_pc[r_q_rd] + 32'd4;
         r_valid_d <= 1'b1;
      end else if (w_bypass) begin
         r_instr_d <= ImemRData;
         r_pc_d    <= w_tag_pc;
         r_pcp4_d  <= w_tag_pc + 32'd4;
         r_valid_d <= 1'b1;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] r_stat_bub, r_stat_dis;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_bub <= '0;
         r_stat_dis <= '0;
      end else begin
         if (w_bubble) r_stat_bub <= r_stat_bub + 32'd1;
         if (w_drop) r_stat_dis <= r_stat_dis + 32'd1;
      end
   end
   assign StatBubbles  = r_stat_bub;
   assign StatDiscards = r_stat_dis;
`endif
endmodule
